aes_key_expand: RTL and testbench

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

---
 rtl/aes_key_expand.sv | 255 +++++++++++++++++++++++++
 tb/tb_aes_key_expand.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// aes_key_expand -- streaming AES key schedule (FIPS-197 KeyExpansion).
//
// Expands a 128-bit cipher key into round keys 0..Nr. One schedule word is
// produced per unstalled cycle from a sliding window of the last Nk words.
// The S-box is outside this block: sbox_o feeds it and sbox_i must return the
// substituted word combinationally in the same cycle. Round keys leave through
// one output register backed by a single 4-word staging register. A consumer
// that is always ready therefore gets a new key every four cycles without gaps.
// A stalled consumer back-pressures word generation.
//
// Optional feature macro: AES_KEY_EXPAND_WIDE_EN enables 192/256-bit keys.
// Without the macro only AES-128 is accepted, and the window is four words.
//
// Ports:
//   clk, nrst      clock, asynchronous active-low reset
//   start_i        request expansion (accepted only while busy_o=0)
//   key_len_i      00=128, 01=192, 10=256, 11=reserved
//   key_i          cipher key, w0 in the top 32 bits
//   sbox_o/sbox_i  word to and from the shared external S-box
//   rk_o           round key, w[4r] in bits 127:96
//   rk_idx_o       round number of rk_o
//   rk_valid_o     rk_o valid; handshake with rk_ready_i
//   busy_o         expansion in progress
//   done_o         pulse after the last round key is accepted
//   err_o          pulse after a rejected start
module aes_key_expand #(
  parameter int MAX_NK = 8
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 start_i,
  input  logic [1:0]           key_len_i,
  input  logic [32*MAX_NK-1:0] key_i,
  output logic [31:0]          sbox_o,
  input  logic [31:0]          sbox_i,
  output logic [127:0]         rk_o,
  output logic [3:0]           rk_idx_o,
  output logic                 rk_valid_o,
  input  logic                 rk_ready_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

`ifdef AES_KEY_EXPAND_WIDE_EN
  localparam int WIN = MAX_NK;
`else
  localparam int WIN = 4;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DRAIN = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [31:0] win [WIN];    // window; win[WIN-1] holds the newest word
  logic [31:0] win_init [WIN];
  logic [31:0] stg [4];
  logic [2:0]  stg_cnt;
  logic [5:0]  widx;         // index i of the next word to compute
  logic [2:0]  mod_cnt;      // i mod Nk
  logic [7:0]  rcon;
  logic [3:0]  nk, nr;
  logic [3:0]  nk_start, nr_start;
  logic        len_ok, accept, reject, hs, out_free, stg_full;
  logic        gen, key_avail, load_out, last_w;
  logic [31:0] prev_w, old_w, temp_w, new_w;
  logic [31:0] kw [8];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Split key_i into words; words beyond MAX_NK read as zero.
  for (genvar m = 0; m < 8; m++) begin : g_kw
    if (m < MAX_NK) begin : g_use
      assign kw[m] = key_i[32*(MAX_NK-1-m) +: 32];
    end else begin : g_zero
      assign kw[m] = 32'h0;
    end
  end

  // Decode the requested key length into Nk/Nr and legality.
  always_comb begin
    nk_start = 4'd4;
    nr_start = 4'd10;
    len_ok   = 1'b0;
`ifdef AES_KEY_EXPAND_WIDE_EN
    case (key_len_i)
      2'b00:   begin nk_start = 4'd4; nr_start = 4'd10; len_ok = 1'b1; end
      2'b01:   begin nk_start = 4'd6; nr_start = 4'd12; len_ok = 1'b1; end
      2'b10:   begin nk_start = 4'd8; nr_start = 4'd14; len_ok = 1'b1; end
      default: begin nk_start = 4'd4; nr_start = 4'd10; len_ok = 1'b0; end
    endcase
    // A key longer than the window cannot be held.
    if (int'(nk_start) > WIN) begin
      len_ok = 1'b0;
    end else begin
      len_ok = len_ok;
    end
`else
    case (key_len_i)
      2'b00:   len_ok = 1'b1;
      default: len_ok = 1'b0;
    endcase
`endif
  end

  // Initial window: the key words right-aligned so the newest is on top.
  always_comb begin
    for (int j = 0; j < WIN; j++) begin
      if (j >= WIN - int'(nk_start)) begin
        win_init[j] = kw[3'(j - (WIN - int'(nk_start)))];
      end else begin
        win_init[j] = 32'h0;
      end
    end
  end

  // Handshake, stall and key-availability decisions.
  always_comb begin
    accept    = start_i && (state == IDLE) && len_ok;
    reject    = start_i && (state == IDLE) && !len_ok;
    hs        = rk_valid_o && rk_ready_i;
    out_free  = !rk_valid_o || rk_ready_i;
    stg_full  = (stg_cnt == 3'd4);
    gen       = (state == EXPAND) && (!stg_full || out_free);
    // A key is ready when staging is full, or when this word completes it.
    key_avail = stg_full || (gen && (stg_cnt == 3'd3));
    load_out  = key_avail && out_free;
    last_w    = (widx == {nr, 2'b11});
  end

  // Word computation: one schedule step w[i] = w[i-Nk] ^ temp.
  always_comb begin
    prev_w = win[WIN-1];
    old_w  = 32'h0;
    for (int j = 0; j < WIN; j++) begin
      old_w = (j == WIN - int'(nk)) ? win[j] : old_w;
    end
    if ((state == EXPAND) && (mod_cnt == 3'd0)) begin
      sbox_o = {prev_w[23:0], prev_w[31:24]};
      temp_w = sbox_i ^ {rcon, 24'h000000};
    end else if ((state == EXPAND) && (nk == 4'd8) && (mod_cnt == 3'd4)) begin
      sbox_o = prev_w;
      temp_w = sbox_i;
    end else begin
      sbox_o = 32'h0;
      temp_w = prev_w;
    end
    new_w = old_w ^ temp_w;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = EXPAND;
        else        state_nxt = IDLE;
      end
      EXPAND: begin
        if (gen && last_w) state_nxt = DRAIN;
        else               state_nxt = EXPAND;
      end
      DRAIN: begin
        if (hs && (rk_idx_o == nr)) state_nxt = IDLE;
        else                        state_nxt = DRAIN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and status pulses.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_o <= (state_nxt != IDLE);
      done_o <= (state == DRAIN) && hs && (rk_idx_o == nr);
      err_o  <= reject;
    end
  end

  // Window, staging and output register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int j = 0; j < WIN; j++) win[j] <= 32'h0;
      for (int j = 0; j < 4; j++)   stg[j] <= 32'h0;
      stg_cnt    <= 3'd0;
      widx       <= 6'd0;
      mod_cnt    <= 3'd0;
      rcon       <= 8'h01;
      nk         <= 4'd4;
      nr         <= 4'd10;
      rk_o       <= 128'h0;
      rk_idx_o   <= 4'd0;
      rk_valid_o <= 1'b0;
    end else if (accept) begin
      for (int j = 0; j < WIN; j++) win[j] <= win_init[j];
      nk         <= nk_start;
      nr         <= nr_start;
      widx       <= {2'b00, nk_start};
      mod_cnt    <= 3'd0;
      rcon       <= 8'h01;
      rk_o       <= {kw[0], kw[1], kw[2], kw[3]};
      rk_idx_o   <= 4'd0;
      rk_valid_o <= 1'b1;
      // Key words beyond w3 already belong to round 1.
      case (nk_start)
        4'd6: begin
          stg[0] <= kw[4]; stg[1] <= kw[5]; stg[2] <= 32'h0; stg[3] <= 32'h0;
          stg_cnt <= 3'd2;
        end
        4'd8: begin
          stg[0] <= kw[4]; stg[1] <= kw[5]; stg[2] <= kw[6]; stg[3] <= kw[7];
          stg_cnt <= 3'd4;
        end
        default: begin
          for (int j = 0; j < 4; j++) stg[j] <= 32'h0;
          stg_cnt <= 3'd0;
        end
      endcase
    end else begin
      if (gen) begin
        for (int j = 0; j < WIN-1; j++) win[j] <= win[j+1];
        win[WIN-1] <= new_w;
        widx       <= widx + 6'd1;
        mod_cnt    <= ({1'b0, mod_cnt} == nk - 4'd1) ? 3'd0 : mod_cnt + 3'd1;
        if (mod_cnt == 3'd0) rcon <= xtime(rcon);
      end
      if (load_out) begin
        // A key completed by this cycle's word bypasses staging.
        rk_o       <= {stg[0], stg[1], stg[2], stg_full ? stg[3] : new_w};
        rk_idx_o   <= rk_idx_o + 4'd1;
        rk_valid_o <= 1'b1;
        if (stg_full && gen) begin
          stg[0]  <= new_w;
          stg_cnt <= 3'd1;
        end else begin
          stg_cnt <= 3'd0;
        end
      end else begin
        if (hs) rk_valid_o <= 1'b0;
        if (gen) begin
          stg[stg_cnt[1:0]] <= new_w;
          stg_cnt           <= stg_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: the stimulus pushes expected round keys,
// and a negedge monitor pops them on every handshake and compares them.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         nrst;
  logic         start_i;
  logic [1:0]   key_len_i;
  logic [255:0] key_i;
  logic [31:0]  sbox_o, sbox_i;
  logic [127:0] rk_o;
  logic [3:0]   rk_idx_o;
  logic         rk_valid_o, rk_ready_i, busy_o, done_o, err_o;

  aes_key_expand #(.MAX_NK(8)) dut (
    .clk(clk), .nrst(nrst), .start_i(start_i), .key_len_i(key_len_i),
    .key_i(key_i), .sbox_o(sbox_o), .sbox_i(sbox_i), .rk_o(rk_o),
    .rk_idx_o(rk_idx_o), .rk_valid_o(rk_valid_o), .rk_ready_i(rk_ready_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External AES S-box
  logic [0:2047] sbox_tab = 2048'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0b7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b27509832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cfd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2cd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdbe0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08ba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9ee1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16;

  function automatic logic [7:0] sb(input logic [7:0] b);
    return sbox_tab[int'(b)*8 +: 8];
  endfunction

  assign sbox_i = {sb(sbox_o[31:24]), sb(sbox_o[23:16]), sb(sbox_o[15:8]), sb(sbox_o[7:0])};

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] rk;
    bit           chk;
    int           cyc;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         e_mon;
  int           ncomp = 0, nfail = 0;
  int           done_cnt = 0, err_cnt = 0, exp_done = -1;
  logic         stall_prev = 1'b0;
  logic [127:0] prev_rk;
  logic [3:0]   prev_idx;
  logic [127:0] exp128 [11];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    ncomp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int idx, input logic [127:0] rk, input bit chk, input int c);
    exp_t e;
    e.idx = 4'(idx); e.rk = rk; e.chk = chk; e.cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic drive_start(input logic [255:0] key, input logic [1:0] len, output int t);
    @(posedge clk); #2;
    key_i = key; key_len_i = len; start_i = 1'b1;
    t = cyc;
  endtask

  task automatic end_start();
    @(posedge clk); #2;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int d0, input string name);
    for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
    if (done_cnt == d0) begin
      ncomp++; nfail++;
      $display("FAIL %s_timeout: got no done_o within %0d cycles", name, budget);
    end
    repeat (3) @(posedge clk);
    #2;
    check({name, "_done_once"}, 128'(done_cnt), 128'(d0 + 1));
    check({name, "_sb_empty"}, 128'(sb_q.size()), 128'd0);
    check({name, "_busy_low"}, 128'(busy_o), 128'd0);
  endtask

  task automatic illegal_start(input logic [1:0] len, input string name);
    int t;
    drive_start(K256, len, t);
    end_start();
    check({name, "_err_pulse"}, 128'({err_o, busy_o}), 128'b10);
    @(posedge clk); #2;
    check({name, "_err_clear"}, 128'({err_o, busy_o, rk_valid_o}), 128'b000);
  endtask

  // AES-128 with a always-ready consumer and exact cycle expectations.
  task automatic run128_timed(input string name);
    int t, d0;
    d0 = done_cnt;
    drive_start(K128, 2'b00, t);
    for (int r = 0; r <= 10; r++) push(r, exp128[r], 1'b1, t + 4*r + 1);
    exp_done = t + 42;
    end_start();
    check({name, "_busy_high"}, 128'(busy_o), 128'd1);
    wait_done(200, d0, name);
    exp_done = -1;
  endtask

  // Monitor: pops the scoreboard on each handshake and checks hold-while-stalled.
  initial begin
    forever begin
      @(negedge clk);
      if (nrst && stall_prev) begin
        check("stall_hold", {rk_valid_o, rk_idx_o, rk_o[122:0]}, {1'b1, prev_idx, prev_rk[122:0]});
        check("stall_hold_top", 128'(rk_o[127:123]), 128'(prev_rk[127:123]));
      end
      if (rk_valid_o && rk_ready_i) begin
        if (sb_q.size() == 0) begin
          ncomp++; nfail++;
          $display("FAIL unexpected_key: got idx %0d %h expected no key", rk_idx_o, rk_o);
        end else begin
          e_mon = sb_q.pop_front();
          check("rk_idx", 128'(rk_idx_o), 128'(e_mon.idx));
          if (e_mon.chk) check("rk_value", rk_o, e_mon.rk);
          if (e_mon.cyc >= 0) check("rk_cycle", 128'(cyc), 128'(e_mon.cyc));
        end
      end
      if (done_o) begin
        done_cnt++;
        if (exp_done >= 0) check("done_cycle", 128'(cyc), 128'(exp_done));
      end
      if (err_o) err_cnt++;
      stall_prev = nrst && rk_valid_o && !rk_ready_i;
      prev_rk    = rk_o;
      prev_idx   = rk_idx_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, d0, e0;
    exp128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp128[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    nrst = 1'b1; start_i = 1'b0; key_len_i = 2'b00; key_i = '0; rk_ready_i = 1'b1;
    #3 nrst = 1'b0;
    #4;
    check("reset_ctrl", 128'({rk_valid_o, busy_o, done_o, err_o, rk_idx_o}), 128'd0);
    check("reset_rk", rk_o, 128'd0);
    check("reset_sbox", 128'(sbox_o), 128'd0);
    @(posedge clk); #2 nrst = 1'b1;

    // AES-128, consumer always ready
    run128_timed("a128");

    // Reserved length
    illegal_start(2'b11, "len11");

`ifdef AES_KEY_EXPAND_WIDE_EN
    // AES-192
    d0 = done_cnt;
    drive_start(K192, 2'b01, t);
    push(0, 128'h8e73b0f7da0e6452c810f32b809079e5, 1'b1, -1);
    for (int r = 1; r <= 11; r++) push(r, 128'h0, 1'b0, -1);
    push(12, 128'he98ba06f448c773c8ecc720401002202, 1'b1, -1);
    end_start();
    wait_done(300, d0, "a192");

    // AES-256
    d0 = done_cnt;
    drive_start(K256, 2'b10, t);
    push(0, 128'h603deb1015ca71be2b73aef0857d7781, 1'b1, -1);
    push(1, 128'h1f352c073b6108d72d9810a30914dff4, 1'b1, -1);
    for (int r = 2; r <= 13; r++) push(r, 128'h0, 1'b0, -1);
    push(14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b1, -1);
    end_start();
    wait_done(300, d0, "a256");
`else
    illegal_start(2'b01, "len01");
    illegal_start(2'b10, "len10");
`endif

    // AES-128 with a randomly stalling consumer; starts while busy are ignored
    d0 = done_cnt;
    e0 = err_cnt;
    drive_start(K128, 2'b00, t);
    for (int r = 0; r <= 10; r++) push(r, exp128[r], 1'b1, -1);
    end_start();
    for (int i = 0; i < 1000 && done_cnt == d0; i++) begin
      @(posedge clk); #2;
      rk_ready_i = 1'($urandom_range(0, 1));
      if (i == 10) begin
        start_i = 1'b1; key_len_i = 2'b11;
      end else if (i == 20) begin
        start_i = 1'b1; key_len_i = 2'b00; key_i = '0;
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    rk_ready_i = 1'b1;
    wait_done(5, d0, "rand");
    check("rand_no_err", 128'(err_cnt), 128'(e0));

    // Reset in the middle of an expansion, after round 5 is handed over
    d0 = done_cnt;
`ifdef AES_KEY_EXPAND_WIDE_EN
    drive_start(K256, 2'b10, t);
    push(0, 128'h603deb1015ca71be2b73aef0857d7781, 1'b1, -1);
    for (int r = 1; r <= 14; r++) push(r, 128'h0, 1'b0, -1);
`else
    drive_start(K128, 2'b00, t);
    for (int r = 0; r <= 10; r++) push(r, exp128[r], 1'b1, -1);
`endif
    end_start();
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        seen = rk_valid_o && rk_ready_i && (rk_idx_o == 4'd5);
      end
      if (!seen) begin
        ncomp++; nfail++;
        $display("FAIL abort_round5_timeout: got no round 5 within 200 cycles");
      end
    end
    #1 nrst = 1'b0;
    #1;
    check("abort_ctrl", 128'({rk_valid_o, busy_o, done_o, err_o, rk_idx_o}), 128'd0);
    check("abort_rk", rk_o, 128'd0);
    check("abort_sbox", 128'(sbox_o), 128'd0);
    sb_q.delete();
    repeat (3) @(posedge clk);
    #2 nrst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("abort_no_done", 128'(done_cnt), 128'(d0));
    check("abort_idle", 128'({busy_o, rk_valid_o}), 128'd0);

    // The first start after reset behaves as after power-up
    run128_timed("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
